// File: rtl/spi_pkg.sv
// Purpose: shared constants, state enum and command decode for the SPI slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    localparam int DATA_W  = 16;
    localparam int COEFF_W = 64;
    localparam int CMD_W   = 8;

    localparam int N_BANK   = 5;           // y1, y2, x0, x1, x2
    localparam int N_COEFF  = 2 * N_BANK;  // hp bank at 0..4, lp bank at 5..9
    localparam int RD_W     = 2 * DATA_W;  // {left, right} read frame
    localparam int CNT_W    = 7;           // must hold COEFF_W (64)

    localparam logic [CMD_W-1:0] CMD_READ    = 8'h01;
    localparam logic [CMD_W-1:0] CMD_HP_BASE = 8'h10;
    localparam logic [CMD_W-1:0] CMD_LP_BASE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        READ,
        WRITE,
        IGNORE
    } state_t;

    // Coefficient write target: vld marks a legal write command,
    // idx is the flat coefficient slot (hp 0..4, lp 5..9).
    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } wr_sel_t;

    function automatic wr_sel_t decode_wr(input logic [CMD_W-1:0] cmd);
        wr_sel_t          sel;
        logic [CMD_W-1:0] off_hp;
        logic [CMD_W-1:0] off_lp;
        sel.vld = 1'b0;
        sel.idx = '0;
        off_hp  = cmd - CMD_HP_BASE;
        off_lp  = cmd - CMD_LP_BASE;
        if (off_hp < CMD_W'(N_BANK)) begin
            sel.vld = 1'b1;
            sel.idx = off_hp[3:0];
        end else if (off_lp < CMD_W'(N_BANK)) begin
            sel.vld = 1'b1;
            sel.idx = 4'(N_BANK) + off_lp[3:0];
        end
        return sel;
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Purpose: SPI pin bundle (host is master, FPGA is slave).
// Latency: n/a (wiring only).
// Backpressure: n/a; SCLK paced entirely by the host.
interface spi_slave_if;
    logic SCLK;  // host clock, idle low
    logic CS;    // chip select, active low
    logic MOSI;  // host -> slave data
    logic MISO;  // slave -> host data, always driven

    modport master (output SCLK, output CS, output MOSI, input MISO);
    modport slave  (input SCLK, input CS, input MOSI, output MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Purpose: 2-flop synchroniser for an async pin with rise/fall pulse outputs.
// Latency: pulse appears 2 clk cycles after the pin settles.
// Backpressure: none.
// Ports: clk/rst_n clock+async reset, i_async raw pin, o_rise/o_fall one-cycle pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // All flops reset low: a pin already low at reset release produces no
    // edge, so a CS held low through reset cannot start a transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// Purpose: mode-0 SPI slave; host reads {left,right} and writes ten biquad coefficients.
// Latency: coefficient updates 1 clk_48 after the synchronised 64th SCLK rise; MISO ~3 clk_48 after SCLK fall.
// Backpressure: none; host paces transfers, clk_48 must be at least 4x SCLK.
// Ports: clk_48/reset_n clock+async reset, spi pin bundle, left/right samples in,
//        hp_*/lp_* coefficient outputs (registered, reset to 0).
module spi_slave
    import spi_pkg::*;
(
    input  logic                      clk_48,
    input  logic                      reset_n,
    spi_slave_if.slave                spi,
    input  logic signed [DATA_W-1:0]  left,
    input  logic signed [DATA_W-1:0]  right,
    output logic signed [COEFF_W-1:0] hp_y1_coeff,
    output logic signed [COEFF_W-1:0] hp_y2_coeff,
    output logic signed [COEFF_W-1:0] hp_x0_coeff,
    output logic signed [COEFF_W-1:0] hp_x1_coeff,
    output logic signed [COEFF_W-1:0] hp_x2_coeff,
    output logic signed [COEFF_W-1:0] lp_y1_coeff,
    output logic signed [COEFF_W-1:0] lp_y2_coeff,
    output logic signed [COEFF_W-1:0] lp_x0_coeff,
    output logic signed [COEFF_W-1:0] lp_x1_coeff,
    output logic signed [COEFF_W-1:0] lp_x2_coeff
);

    logic w_sclk_rise, w_sclk_fall;
    logic w_cs_rise, w_cs_fall;

    spi_sync_edge u_sclk_sync (
        .clk    (clk_48),
        .rst_n  (reset_n),
        .i_async(spi.SCLK),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge u_cs_sync (
        .clk    (clk_48),
        .rst_n  (reset_n),
        .i_async(spi.CS),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // MOSI shares the SCLK synchroniser depth, so r_mosi_sync lines up with w_sclk_rise.
    logic r_mosi_meta, r_mosi_sync;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= spi.MOSI;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_bit_cnt;
    logic [CMD_W-2:0]          r_cmd_shift;   // first 7 command bits; 8th comes straight from MOSI
    logic [RD_W-1:0]           r_rd_shift;
    logic [COEFF_W-2:0]        r_stage;       // first 63 data bits; 64th comes straight from MOSI
    logic [3:0]                r_wr_idx;
    logic                      r_miso;
    logic signed [COEFF_W-1:0] r_coeff [N_COEFF];

    logic [CMD_W-1:0] w_cmd_byte;
    logic             w_cmd_last;
    wr_sel_t          w_sel;

    assign w_cmd_byte = {r_cmd_shift, r_mosi_sync};
    assign w_cmd_last = (r_bit_cnt == CNT_W'(CMD_W - 1));
    assign w_sel      = decode_wr(w_cmd_byte);

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_cs_fall) w_state_nxt = CMD;
            CMD: begin
                if (w_sclk_rise && w_cmd_last) begin
                    if (w_cmd_byte == CMD_READ) w_state_nxt = READ;
                    else if (w_sel.vld)         w_state_nxt = WRITE;
                    else                        w_state_nxt = IGNORE;
                end
            end
            default: ;
        endcase
        // Deselect wins from any state; partial commands/writes are dropped.
        if (w_cs_rise) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt   <= '0;
            r_cmd_shift <= '0;
            r_rd_shift  <= '0;
            r_stage     <= '0;
            r_wr_idx    <= '0;
            r_miso      <= 1'b0;
            for (int i = 0; i < N_COEFF; i++) r_coeff[i] <= '0;
        end else if (w_cs_rise) begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_miso    <= 1'b0;
                end
                CMD: begin
                    if (w_sclk_rise) begin
                        r_cmd_shift <= {r_cmd_shift[CMD_W-3:0], r_mosi_sync};
                        if (w_cmd_last) begin
                            r_bit_cnt  <= '0;
                            r_rd_shift <= {left, right};  // snapshot at decode
                            r_wr_idx   <= w_sel.idx;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_sclk_fall) begin
                        if (r_bit_cnt < CNT_W'(RD_W)) begin
                            r_miso     <= r_rd_shift[RD_W-1];
                            r_rd_shift <= {r_rd_shift[RD_W-2:0], 1'b0};
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                        end else begin
                            r_miso <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (w_sclk_rise && (r_bit_cnt < CNT_W'(COEFF_W))) begin
                        r_stage   <= {r_stage[COEFF_W-3:0], r_mosi_sync};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == CNT_W'(COEFF_W - 1))
                            r_coeff[r_wr_idx] <= {r_stage, r_mosi_sync};
                    end
                end
                default: r_miso <= 1'b0;
            endcase
        end
    end

    assign spi.MISO = r_miso;

    assign hp_y1_coeff = r_coeff[0];
    assign hp_y2_coeff = r_coeff[1];
    assign hp_x0_coeff = r_coeff[2];
    assign hp_x1_coeff = r_coeff[3];
    assign hp_x2_coeff = r_coeff[4];
    assign lp_y1_coeff = r_coeff[5];
    assign lp_y2_coeff = r_coeff[6];
    assign lp_x0_coeff = r_coeff[7];
    assign lp_x1_coeff = r_coeff[8];
    assign lp_x2_coeff = r_coeff[9];

endmodule

// File: tb/tb_spi_slave.sv
// Purpose: self-checking bench for spi_slave acting as the SPI host.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave;

    localparam int HALF = 60;  // SCLK half period in ns (clk_48 period is 10 ns)

    logic clk_48 = 1'b0;
    logic reset_n;
    always #5 clk_48 = ~clk_48;

    spi_slave_if u_if ();

    logic signed [15:0] left, right;
    logic signed [63:0] hp_y1_coeff, hp_y2_coeff, hp_x0_coeff, hp_x1_coeff, hp_x2_coeff;
    logic signed [63:0] lp_y1_coeff, lp_y2_coeff, lp_x0_coeff, lp_x1_coeff, lp_x2_coeff;

    spi_slave dut (
        .clk_48     (clk_48),
        .reset_n    (reset_n),
        .spi        (u_if),
        .left       (left),
        .right      (right),
        .hp_y1_coeff(hp_y1_coeff),
        .hp_y2_coeff(hp_y2_coeff),
        .hp_x0_coeff(hp_x0_coeff),
        .hp_x1_coeff(hp_x1_coeff),
        .hp_x2_coeff(hp_x2_coeff),
        .lp_y1_coeff(lp_y1_coeff),
        .lp_y2_coeff(lp_y2_coeff),
        .lp_x0_coeff(lp_x0_coeff),
        .lp_x1_coeff(lp_x1_coeff),
        .lp_x2_coeff(lp_x2_coeff)
    );

    logic [63:0] got_coeff [10];
    assign got_coeff[0] = hp_y1_coeff;
    assign got_coeff[1] = hp_y2_coeff;
    assign got_coeff[2] = hp_x0_coeff;
    assign got_coeff[3] = hp_x1_coeff;
    assign got_coeff[4] = hp_x2_coeff;
    assign got_coeff[5] = lp_y1_coeff;
    assign got_coeff[6] = lp_y2_coeff;
    assign got_coeff[7] = lp_x0_coeff;
    assign got_coeff[8] = lp_x1_coeff;
    assign got_coeff[9] = lp_x2_coeff;

    logic [63:0] exp_coeff [10];  // reference model of the coefficient bank
    logic [31:0] rd_q [$];        // expected {left,right} per read transaction
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_coeffs(input string tag);
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("%s coeff%0d", tag, i), got_coeff[i], exp_coeff[i]);
    endtask

    // One mode-0 bit: MOSI set while SCLK low, MISO sampled just before the rise.
    task automatic spi_bit(input logic b, output logic miso);
        u_if.MOSI = b;
        #HALF;
        miso = u_if.MISO;
        u_if.SCLK = 1'b1;
        #HALF;
        u_if.SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        logic m;
        for (int i = 7; i >= 0; i--) spi_bit(v[i], m);
    endtask

    task automatic cs_assert();
        u_if.CS = 1'b0;
        #100;
    endtask

    task automatic cs_release();
        #HALF;
        u_if.CS = 1'b1;
        #100;
    endtask

    // Write nbits of data (MSB first); the model only updates on a complete legal write.
    task automatic spi_write(input logic [7:0] cmd, input logic [63:0] data, input int nbits);
        logic m;
        int   idx;
        cs_assert();
        spi_byte(cmd);
        for (int i = 0; i < nbits; i++) spi_bit(data[63-i], m);
        cs_release();
        idx = -1;
        if (cmd >= 8'h10 && cmd <= 8'h14) idx = int'(cmd) - 16'h10;
        if (cmd >= 8'h20 && cmd <= 8'h24) idx = int'(cmd) - 16'h20 + 5;
        if (idx >= 0 && nbits >= 64) exp_coeff[idx] = data;
    endtask

    // Read transaction; right is bumped after bit change_at to prove the snapshot holds.
    task automatic spi_read(input string tag, input int change_at, input int extra);
        logic        m;
        logic [31:0] cap;
        logic [31:0] exp;
        logic        extra_or;
        rd_q.push_back({left, right});
        cs_assert();
        spi_byte(8'h01);
        cap = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == change_at) right = right + 16'sh1111;
            spi_bit(1'b0, m);
            cap = {cap[30:0], m};
        end
        extra_or = 1'b0;
        for (int i = 0; i < extra; i++) begin
            spi_bit(1'b1, m);
            extra_or = extra_or | m;
        end
        cs_release();
        check_eq({tag, " queue"}, 64'(rd_q.size()), 64'd1);
        if (rd_q.size() > 0) begin
            exp = rd_q.pop_front();
            check_eq({tag, " left"},  64'(cap[31:16]), 64'(exp[31:16]));
            check_eq({tag, " right"}, 64'(cap[15:0]),  64'(exp[15:0]));
        end
        if (extra > 0) check_eq({tag, " miso_extra"}, 64'(extra_or), 64'd0);
    endtask

    initial begin
        logic        m;
        logic        miso_or;
        logic [63:0] d;

        for (int i = 0; i < 10; i++) exp_coeff[i] = '0;
        u_if.SCLK = 1'b0;
        u_if.CS   = 1'b1;
        u_if.MOSI = 1'b0;
        left      = 16'sh1234;
        right     = -16'sd21555;  // 16'hABCD
        reset_n   = 1'b0;
        #100;
        reset_n = 1'b1;
        #100;

        // Reset state and idle SCLK activity with CS high.
        check_eq("rst miso", 64'(u_if.MISO), 64'd0);
        check_coeffs("rst");
        miso_or = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spi_bit(i[0], m);
            miso_or = miso_or | m;
        end
        check_eq("cs_high miso", 64'(miso_or), 64'd0);
        check_coeffs("cs_high");

        // Read with right changed mid-transfer, plus extra clocks after 32 bits.
        spi_read("rd1", 20, 4);
        left  = 16'sh0123;
        right = 16'sh7FFE;
        spi_read("rd2", -1, 0);

        // Single hp_x0 write.
        spi_write(8'h12, 64'h0123_4567_89AB_CDEF, 64);
        check_coeffs("wr_hp_x0");

        // Partial lp_x2 write is dropped, full one lands as -2.
        spi_write(8'h24, 64'hAAAA_5555_AAAA_5555, 40);
        check_coeffs("wr_part");
        spi_write(8'h24, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        check_coeffs("wr_lp_x2");

        // Unknown command: MISO quiet, nothing changes; a read still works after.
        cs_assert();
        spi_byte(8'h7F);
        miso_or = 1'b0;
        for (int i = 0; i < 32; i++) begin
            spi_bit(1'b1, m);
            miso_or = miso_or | m;
        end
        cs_release();
        check_eq("ign miso", 64'(miso_or), 64'd0);
        check_coeffs("ign");
        left  = -16'sd32767;  // 16'h8001
        right = 16'sh5A5A;
        spi_read("rd3", -1, 0);

        // Every coefficient slot with random data.
        for (int i = 0; i < 10; i++) begin
            d = {$urandom, $urandom};
            spi_write((i < 5) ? 8'(8'h10 + i) : 8'(8'h20 + i - 5), d, 64);
        end
        check_coeffs("wr_all");

        // Async reset mid-write; remaining bits with CS still low must not land.
        cs_assert();
        spi_byte(8'h20);
        for (int i = 0; i < 20; i++) spi_bit(i[0], m);
        reset_n = 1'b0;
        #30;
        for (int i = 0; i < 10; i++) exp_coeff[i] = '0;
        check_eq("arst miso", 64'(u_if.MISO), 64'd0);
        check_coeffs("arst");
        reset_n = 1'b1;
        #30;
        for (int i = 0; i < 44; i++) spi_bit(1'b1, m);
        cs_release();
        check_coeffs("post_arst");
        left  = 16'sh4321;
        right = 16'sh0F0F;
        spi_read("rd4", -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (mode 0) bridging an external host (Raspberry Pi) to the FPGA channel strip.
- Host reads the current left/right audio samples (command 0x01).
- Host writes the ten 64-bit biquad coefficients for the high-pass and low-pass filters.
- SPI pins are oversampled in the clk_48 domain; no logic is clocked by SCLK.

Parameters:
- DATA_W, 16, audio sample width.
- COEFF_W, 64, coefficient width.
- CMD_W, 8, command byte width.

Ports:
- clk_48  in  1  system clock; all logic clocked on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from host, idle low; asynchronous to clk_48.
- CS  in  1  chip select, active low, asynchronous.
- MOSI  in  1  host-to-slave serial data.
- MISO  out  1  slave-to-host serial data.
- left  in  16 signed  current left sample.
- right  in  16 signed  current right sample.
- hp_y1_coeff, hp_y2_coeff, hp_x0_coeff, hp_x1_coeff, hp_x2_coeff  out  64 signed each  high-pass coefficients.
- lp_y1_coeff, lp_y2_coeff, lp_x0_coeff, lp_x1_coeff, lp_x2_coeff  out  64 signed each  low-pass coefficients.

Behaviour:
- Synchronisation and edges:
  - SCLK, CS and MOSI pass through 2-flop synchronisers.
  - Rising/falling SCLK edges are detected in clk_48.
  - Requirement: f(clk_48) >= 4 x f(SCLK).
- Mode 0 timing: MOSI is sampled on the detected SCLK rise; MISO is updated on the detected SCLK fall. All bits are MSB first.
- Reset (or CS high): state IDLE, bit counter 0, MISO 0. All ten coefficient outputs reset to 0.
- IDLE: synchronised CS falling → CMD, counter cleared.
- CMD: shift 8 MOSI bits. On the 8th rise, decode the command:
  - 0x01 READ: snapshot {left,right} into a 32-bit shift register → READ.
  - 0x10-0x14 write hp_y1, hp_y2, hp_x0, hp_x1, hp_x2 → WRITE.
  - 0x20-0x24 write lp_y1, lp_y2, lp_x0, lp_x1, lp_x2 → WRITE.
  - Any other value → IGNORE.
- READ:
  - On the SCLK fall after the 8th rise, MISO = left[15].
  - Each subsequent fall shifts: left[14..0], then right[15..0].
  - The host samples MISO on rises 9-40.
  - After 32 bits, MISO = 0 for any extra clocks.
- WRITE:
  - Shift 64 MOSI bits into a staging register.
  - On the 64th rise, copy it to the addressed coefficient output; the output changes on the following clk_48 cycle.
  - Further bits are ignored until CS rises.
- IGNORE: MISO = 0; no outputs change.
- CS rising, from any state → IDLE, MISO 0.
  - A partial command or a partial write (< 64 bits) is discarded; coefficients are unchanged.
- MISO is driven low, never tri-stated, whenever not in READ.
- Snapshot values are those of left/right in the clk_48 cycle the command is decoded. Later changes do not affect the transfer in progress.
- Asynchronous reset mid-transfer: immediate return to the reset state. The next transaction requires a fresh CS falling edge.
- No arithmetic is performed; coefficients pass through bit-exact.

Decomposition:
- Shared package spi_pkg holds:
  - CMD_READ=8'h01 and the hp/lp write command codes (base 8'h10 / 8'h20, index 0-4 = y1, y2, x0, x1, x2).
  - DATA_W, COEFF_W, CMD_W.
  - State enum {IDLE, CMD, READ, WRITE, IGNORE}.
- One sub-module, spi_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs. Instantiate for SCLK and CS; MOSI uses a plain synchroniser.

Test Plan:
- Reset with CS high → all coefficients 0, MISO 0; no change while SCLK toggles with CS high.
- left=16'h1234, right=16'hABCD; CS low, send 0x01, 32 more clocks → host captures left 0x1234, right 0xABCD. Raise right mid-transfer → captured value still 0xABCD.
- Send 0x12 + 64'h0123_4567_89AB_CDEF, CS high → hp_x0_coeff = 64'h0123456789ABCDEF; the other nine coefficients remain 0.
- Send 0x24 + 40 bits, then CS high → lp_x2_coeff unchanged. Next full transaction 0x24 + 64'hFFFF_FFFF_FFFF_FFFE → lp_x2_coeff = -2.
- Send 0x7F + 32 clocks → MISO stays 0; no coefficient changes. A following 0x01 read still works.
- Assert reset_n=0 midway through a write of 0x20 → all coefficients 0, MISO 0. Subsequent 0x01 read returns the correct left/right.
